collision_scorer: RTL and testbench



---
 rtl/collision_scorer.sv | 193 +++++++++++++++++++
 tb/tb_collision_scorer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/collision_scorer.sv
// Collision detector and BCD scorer for the runner game.
// Checks the runner against the obstacle on every scroll tick, keeps the
// current and high score in BCD, and drives active-low 7-segment codes.
module collision_scorer #(
  parameter int unsigned SCORE_DIV   = 1,
  parameter int unsigned GRACE_TICKS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        move,
  input  logic        tick,
  input  logic [4:0]  runner_height,
  input  logic [1:0]  obstacle_col,
  output logic        stop_req,
  output logic        game_over,
  output logic [15:0] score_bcd,
  output logic [15:0] hi_bcd,
  output logic [27:0] hex_score
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  localparam logic [3:0] GRACE_INIT = 4'(GRACE_TICKS);
  localparam logic [3:0] DIV_LAST   = 4'(SCORE_DIV - 1);

  state_t      state_q, state_d;
  logic [3:0]  grace_q, grace_d;
  logic [3:0]  div_q, div_d;
  logic [15:0] score_q, score_d;
  logic [15:0] hi_q, hi_d;
  logic        stop_q, stop_d;
  logic        over_q, over_d;
  logic        collide_s;

  // BCD increment with per-digit carry; 9999 saturates instead of wrapping.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v == 16'h9999) begin
      r = v;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (v[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Active-low segment code, bit0 = a .. bit6 = g; non-BCD values blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Runner occupies rows h..h+3, obstacle rows 1..col: overlap iff h <= col.
  assign collide_s = (obstacle_col != 2'd0) && (runner_height <= {3'd0, obstacle_col});

  // Next-state and datapath updates for the game FSM.
  always_comb begin
    state_d = state_q;
    grace_d = grace_q;
    div_d   = div_q;
    score_d = score_q;
    hi_d    = hi_q;
    stop_d  = 1'b0;
    over_d  = over_q;
    case (state_q)
      ST_IDLE: begin
        score_d = 16'h0000;
        div_d   = 4'd0;
        grace_d = 4'd0;
        over_d  = 1'b0;
        if (move && !start) begin
          state_d = ST_RUN;
          grace_d = GRACE_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (start) begin
          // Player stopped the run: bank the score before returning to idle.
          state_d = ST_IDLE;
          if (score_q > hi_q) begin
            hi_d = score_q;
          end else begin
            hi_d = hi_q;
          end
        end else if (tick) begin
          if ((grace_q != 4'd0) || !collide_s) begin
            if (grace_q != 4'd0) begin
              grace_d = grace_q - 4'd1;
            end else begin
              grace_d = grace_q;
            end
            if (div_q >= DIV_LAST) begin
              div_d   = 4'd0;
              score_d = bcd_inc(score_q);
            end else begin
              div_d   = div_q + 4'd1;
            end
          end else begin
            state_d = ST_HIT;
            stop_d  = 1'b1;
            over_d  = 1'b1;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HIT: begin
        over_d  = 1'b1;
        state_d = ST_OVER;
        if (score_q > hi_q) begin
          hi_d = score_q;
        end else begin
          hi_d = hi_q;
        end
      end
      ST_OVER: begin
        if (move) begin
          state_d = ST_RUN;
          score_d = 16'h0000;
          div_d   = 4'd0;
          grace_d = GRACE_INIT;
          over_d  = 1'b0;
        end else begin
          over_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grace_q <= 4'd0;
      div_q   <= 4'd0;
      score_q <= 16'h0000;
      hi_q    <= 16'h0000;
      stop_q  <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grace_q <= grace_d;
      div_q   <= div_d;
      score_q <= score_d;
      hi_q    <= hi_d;
      stop_q  <= stop_d;
      over_q  <= over_d;
    end
  end

  assign stop_req  = stop_q;
  assign game_over = over_q;
  assign score_bcd = score_q;
  assign hi_bcd    = hi_q;
  assign hex_score = {seg7(score_q[15:12]), seg7(score_q[11:8]),
                      seg7(score_q[7:4]),   seg7(score_q[3:0])};

endmodule

// File: tb/tb_collision_scorer.sv
// Scoreboard bench for collision_scorer: stimulus pushes expected snapshots
// and expected stop pulses; a negedge monitor pops and compares them.
module tb_collision_scorer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        move;
  logic        tick;
  logic [4:0]  runner_height;
  logic [1:0]  obstacle_col;
  logic        stop_req, game_over;
  logic [15:0] score_bcd, hi_bcd;
  logic [27:0] hex_score;
  logic        stop_req3, game_over3;
  logic [15:0] score_bcd3, hi_bcd3;
  logic [27:0] hex_score3;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S9 = 7'b0010000;

  typedef struct {
    int          cyc;
    string       name;
    bit          use3;
    logic [15:0] score;
    logic [15:0] hi;
    logic        go;
    logic        sr;
    bit          chk_hex;
    logic [27:0] hex;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] stop_q[$];
  int          cyc;
  int          errors;
  int          checks;

  collision_scorer dut (
    .clk(clk), .reset(reset), .start(start), .move(move), .tick(tick),
    .runner_height(runner_height), .obstacle_col(obstacle_col),
    .stop_req(stop_req), .game_over(game_over), .score_bcd(score_bcd),
    .hi_bcd(hi_bcd), .hex_score(hex_score)
  );

  collision_scorer #(.SCORE_DIV(3), .GRACE_TICKS(2)) dut3 (
    .clk(clk), .reset(reset), .start(start), .move(move), .tick(tick),
    .runner_height(runner_height), .obstacle_col(obstacle_col),
    .stop_req(stop_req3), .game_over(game_over3), .score_bcd(score_bcd3),
    .hi_bcd(hi_bcd3), .hex_score(hex_score3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string name, input bit use3,
                            input logic [15:0] sc, input logic [15:0] hi,
                            input logic go, input logic sr,
                            input bit chk_hex, input logic [27:0] hx);
    exp_t e;
    e.cyc = cyc; e.name = name; e.use3 = use3; e.score = sc; e.hi = hi;
    e.go = go; e.sr = sr; e.chk_hex = chk_hex; e.hex = hx;
    exp_q.push_back(e);
  endtask

  // Monitor: compare queued snapshots for this cycle and every stop pulse.
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] a_sc, a_hi, es;
    logic        a_go, a_sr;
    logic [27:0] a_hx;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      a_sc = e.use3 ? score_bcd3 : score_bcd;
      a_hi = e.use3 ? hi_bcd3    : hi_bcd;
      a_go = e.use3 ? game_over3 : game_over;
      a_sr = e.use3 ? stop_req3  : stop_req;
      a_hx = e.use3 ? hex_score3 : hex_score;
      checks++;
      if (e.cyc != cyc || a_sc !== e.score || a_hi !== e.hi || a_go !== e.go ||
          a_sr !== e.sr || (e.chk_hex && a_hx !== e.hex)) begin
        errors++;
        $display("FAIL %s: got score=%h hi=%h go=%b sr=%b hex=%h, want score=%h hi=%h go=%b sr=%b hex=%h",
                 e.name, a_sc, a_hi, a_go, a_sr, a_hx, e.score, e.hi, e.go, e.sr, e.hex);
      end
    end
    if (stop_req === 1'b1) begin
      checks++;
      if (stop_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_stop_req: got stop_req=1 at cycle %0d, want 0", cyc);
      end else begin
        es = stop_q.pop_front();
        if (score_bcd !== es || game_over !== 1'b1) begin
          errors++;
          $display("FAIL stop_pulse: got score=%h go=%b, want score=%h go=1",
                   score_bcd, game_over, es);
        end
      end
    end
  end

  initial begin
    cyc = 0; errors = 0; checks = 0;
    reset = 1'b1; start = 1'b0; move = 1'b0; tick = 1'b0;
    runner_height = 5'd0; obstacle_col = 2'd0;

    // 1: reset state
    step(); step();
    expect_now("reset", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, {4{S0}});
    reset = 1'b0;

    // 2: twelve clean ticks
    move = 1'b1; step(); move = 1'b0;
    tick = 1'b1;
    repeat (12) step();
    tick = 1'b0;
    expect_now("clean12", 1'b0, 16'h0012, 16'h0000, 1'b0, 1'b0, 1'b1, {S0, S0, S1, S2});

    // 3: fresh game, 5 clean ticks then a collision
    reset = 1'b1; step(); reset = 1'b0;
    move = 1'b1; step(); move = 1'b0;
    tick = 1'b1;
    repeat (5) step();
    expect_now("clean5", 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0, 28'd0);
    runner_height = 5'd1; obstacle_col = 2'd2;
    step();
    expect_now("hit_cycle", 1'b0, 16'h0005, 16'h0000, 1'b1, 1'b1, 1'b0, 28'd0);
    stop_q.push_back(16'h0005);
    tick = 1'b0; obstacle_col = 2'd0;
    step();
    expect_now("hi_update", 1'b0, 16'h0005, 16'h0005, 1'b1, 1'b0, 1'b0, 28'd0);
    start = 1'b1; step(); start = 1'b0;
    expect_now("over_ignores_start", 1'b0, 16'h0005, 16'h0005, 1'b1, 1'b0, 1'b0, 28'd0);

    // 4: restart from OVER, grace hides the first collision
    move = 1'b1; step(); move = 1'b0;
    expect_now("restart", 1'b0, 16'h0000, 16'h0005, 1'b0, 1'b0, 1'b0, 28'd0);
    tick = 1'b1; runner_height = 5'd1; obstacle_col = 2'd2;
    step();
    expect_now("grace_collide", 1'b0, 16'h0001, 16'h0005, 1'b0, 1'b0, 1'b0, 28'd0);
    obstacle_col = 2'd0;
    step(); step();
    obstacle_col = 2'd2;
    step();
    expect_now("hit_after_grace", 1'b0, 16'h0003, 16'h0005, 1'b1, 1'b1, 1'b0, 28'd0);
    stop_q.push_back(16'h0003);
    tick = 1'b0; obstacle_col = 2'd0;
    step();
    expect_now("hi_kept", 1'b0, 16'h0003, 16'h0005, 1'b1, 1'b0, 1'b0, 28'd0);

    // 5: long run with runner just above the obstacle (height 3 vs col 2)
    move = 1'b1; step(); move = 1'b0;
    tick = 1'b1; runner_height = 5'd3; obstacle_col = 2'd2;
    repeat (99) step();
    expect_now("score99", 1'b0, 16'h0099, 16'h0005, 1'b0, 1'b0, 1'b1, {S0, S0, S9, S9});
    step();
    expect_now("score100", 1'b0, 16'h0100, 16'h0005, 1'b0, 1'b0, 1'b1, {S0, S1, S0, S0});
    repeat (9898) step();
    expect_now("score9998", 1'b0, 16'h9998, 16'h0005, 1'b0, 1'b0, 1'b0, 28'd0);
    step();
    expect_now("score9999", 1'b0, 16'h9999, 16'h0005, 1'b0, 1'b0, 1'b1, {4{S9}});
    step();
    expect_now("saturate", 1'b0, 16'h9999, 16'h0005, 1'b0, 1'b0, 1'b1, {4{S9}});
    runner_height = 5'd2;
    step();
    expect_now("hit_edge_equal", 1'b0, 16'h9999, 16'h0005, 1'b1, 1'b1, 1'b0, 28'd0);
    stop_q.push_back(16'h9999);
    tick = 1'b0; obstacle_col = 2'd0; runner_height = 5'd0;
    step();
    expect_now("hi9999", 1'b0, 16'h9999, 16'h9999, 1'b1, 1'b0, 1'b0, 28'd0);

    // 6: divider of 3, reset mid-run, start priority in IDLE
    reset = 1'b1; step(); reset = 1'b0;
    expect_now("div3_reset", 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, {4{S0}});
    move = 1'b1; step(); move = 1'b0;
    tick = 1'b1;
    repeat (7) step();
    expect_now("div1_7", 1'b0, 16'h0007, 16'h0000, 1'b0, 1'b0, 1'b0, 28'd0);
    expect_now("div3_7", 1'b1, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0, 28'd0);
    reset = 1'b1; move = 1'b1;
    step();
    reset = 1'b0; move = 1'b0;
    expect_now("midrun_reset", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 28'd0);
    expect_now("midrun_reset3", 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 28'd0);
    start = 1'b1; move = 1'b1;
    step();
    expect_now("start_priority", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 28'd0);
    start = 1'b0;
    step();
    expect_now("enter_run", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 28'd0);
    step();
    expect_now("first_tick", 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 28'd0);
    tick = 1'b0; move = 1'b0;

    step(); step();
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0 || stop_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d snapshots and %0d stop pulses pending, want 0 and 0",
               exp_q.size(), stop_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
